// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline definitions for the RISC-V stages
//
// Purpose: ResultSrc encodings, memory-interface FSM state type and
//          default datapath widths shared by the pipeline stages.
package pipe_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int RW_DEFAULT   = 5;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/dmem_if_fsm.sv
// rtl/dmem_if_fsm.sv - data-memory handshake FSM for the memory stage
//
// Purpose: decides whether the M-stage instruction needs a data-memory
//          access, drives the request, holds the pipeline until ack and
//          flags misaligned accesses.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   i_mem_write       store request from EX/MEM
//   i_result_src      ResultSrc from EX/MEM (01 = load)
//   i_addr_lo         address bits [1:0] for the alignment check
//   i_ack             memory access complete
//   o_req, o_we       request and direction to data memory
//   o_stall           freeze upstream while access is outstanding
//   o_misalign        misaligned load/store seen this cycle
//   o_load_done       a load completes this cycle (capture rdata)
module dmem_if_fsm
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_mem_write,
  input  logic [1:0] i_result_src,
  input  logic [1:0] i_addr_lo,
  input  logic       i_ack,
  output logic       o_req,
  output logic       o_we,
  output logic       o_stall,
  output logic       o_misalign,
  output logic       o_load_done
);

  mem_state_t r_state;
  mem_state_t w_next;

  logic w_mem_op;
  logic w_misalign;
  logic w_access;

  // A store wins when both store and load encodings are present.
  assign w_mem_op   = i_mem_write | (i_result_src == RES_MEM);
  assign w_misalign = w_mem_op & (i_addr_lo != 2'b00);
  assign w_access   = w_mem_op & ~w_misalign;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_access && !i_ack) w_next = WAIT;
      WAIT:    if (i_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Everything is gated by rst so a pending access is dropped at once and
  // an ack seen while no request is up never completes anything.
  always_comb begin
    o_req       = 1'b0;
    o_misalign  = 1'b0;
    if (rst) begin
      case (r_state)
        IDLE: begin
          o_req      = w_access;
          o_misalign = w_misalign;
        end
        WAIT:    o_req = 1'b1;
        default: o_req = 1'b0;
      endcase
    end
    o_we        = o_req & i_mem_write;
    o_stall     = o_req & ~i_ack;
    o_load_done = o_req & i_ack & ~i_mem_write;
  end

endmodule

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - memory stage of the 5-stage RISC-V pipeline
//
// Purpose: issues loads/stores from the EX/MEM bundle over a handshaked
//          data-memory port, stalls upstream while waiting and registers
//          the MEM/WB bundle.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   RegWriteM .. RD_M             EX/MEM bundle
//   dmem_req/we/addr/wdata        request side of the data-memory port
//   dmem_ack, dmem_rdata          response side of the data-memory port
//   StallM                        freeze F/D/E/M registers
//   MisalignM                     misaligned load/store pulse
//   RegWriteW .. RD_W             MEM/WB bundle
module memory_cycle
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int RW   = RW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [XLEN-1:0] ALU_ResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [RW-1:0]   RD_M,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            StallM,
  output logic            MisalignM,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [XLEN-1:0] ALU_ResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [RW-1:0]   RD_W
);

  logic w_load_done;

  logic            r_reg_write;
  logic [1:0]      r_result_src;
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_read_data;
  logic [XLEN-1:0] r_pc_plus4;
  logic [RW-1:0]   r_rd;

  dmem_if_fsm u_fsm (
    .clk          (clk),
    .rst          (rst),
    .i_mem_write  (MemWriteM),
    .i_result_src (ResultSrcM),
    .i_addr_lo    (ALU_ResultM[1:0]),
    .i_ack        (dmem_ack),
    .o_req        (dmem_req),
    .o_we         (dmem_we),
    .o_stall      (StallM),
    .o_misalign   (MisalignM),
    .o_load_done  (w_load_done)
  );

  assign dmem_addr  = ALU_ResultM;
  assign dmem_wdata = WriteDataM;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_reg_write  <= 1'b0;
      r_result_src <= RES_ALU;
      r_alu_result <= '0;
      r_read_data  <= '0;
      r_pc_plus4   <= '0;
      r_rd         <= '0;
    end else if (StallM) begin
      // Bubble into WB while the access is outstanding.
      r_reg_write <= 1'b0;
    end else begin
      // A misaligned op retires as a bubble.
      r_reg_write  <= RegWriteM & ~MisalignM;
      // The reserved encoding is handed to WB as a plain ALU result.
      r_result_src <= (ResultSrcM == 2'b11) ? RES_ALU : ResultSrcM;
      r_alu_result <= ALU_ResultM;
      r_pc_plus4   <= PCPlus4M;
      r_rd         <= RD_M;
      if (w_load_done) r_read_data <= dmem_rdata;
    end
  end

  assign RegWriteW   = r_reg_write;
  assign ResultSrcW  = r_result_src;
  assign ALU_ResultW = r_alu_result;
  assign ReadDataW   = r_read_data;
  assign PCPlus4W    = r_pc_plus4;
  assign RD_W        = r_rd;

endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - self-checking bench for memory_cycle
module tb_memory_cycle;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } wb_t;

  logic        clk;
  logic        rst;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALU_ResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  RD_M;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        StallM;
  logic        MisalignM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [4:0]  RD_W;

  int  n_checks = 0;
  int  n_errors = 0;
  wb_t exp_q[$];
  wb_t last_w;

  memory_cycle #(.XLEN(32), .RW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .ALU_ResultM (ALU_ResultM),
    .WriteDataM  (WriteDataM),
    .PCPlus4M    (PCPlus4M),
    .RD_M        (RD_M),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .StallM      (StallM),
    .MisalignM   (MisalignM),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW),
    .PCPlus4W    (PCPlus4W),
    .RD_W        (RD_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_w();
    wb_t e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("RegWriteW",   {31'd0, RegWriteW}, {31'd0, e.rw});
      chk("ResultSrcW",  {30'd0, ResultSrcW}, {30'd0, e.rs});
      chk("ALU_ResultW", ALU_ResultW, e.alu);
      chk("ReadDataW",   ReadDataW, e.rdat);
      chk("PCPlus4W",    PCPlus4W, e.pc4);
      chk("RD_W",        {27'd0, RD_W}, {27'd0, e.rd});
    end
  endtask

  task automatic check_port(input logic req, input logic we, input logic stall, input logic mis);
    chk("dmem_req",  {31'd0, dmem_req},  {31'd0, req});
    chk("dmem_we",   {31'd0, dmem_we},   {31'd0, we});
    chk("StallM",    {31'd0, StallM},    {31'd0, stall});
    chk("MisalignM", {31'd0, MisalignM}, {31'd0, mis});
  endtask

  // Drives one instruction at M; called right after a falling edge.
  task automatic do_op(input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] pc4, input logic [4:0] rd,
                       input int waits, input logic [31:0] rdata);
    logic mem, mis, acc;
    int   last;
    wb_t  e;
    mem  = mw | (rs == 2'b01);
    mis  = mem & (addr[1:0] != 2'b00);
    acc  = mem & ~mis;
    last = acc ? waits : 0;
    RegWriteM   = rw;
    MemWriteM   = mw;
    ResultSrcM  = rs;
    ALU_ResultM = addr;
    WriteDataM  = wd;
    PCPlus4M    = pc4;
    RD_M        = rd;
    for (int c = 0; c <= last; c++) begin
      // Without a request the ack is held high to show it is ignored.
      dmem_ack   = acc ? (c == waits) : 1'b1;
      dmem_rdata = (c == last) ? rdata : 32'hBAD0_0000;
      #1;
      check_port(acc, acc & mw, acc && (c < waits), mis);
      if (acc) begin
        chk("dmem_addr",  dmem_addr, addr);
        chk("dmem_wdata", dmem_wdata, wd);
      end
      e = last_w;
      if (acc && (c < waits)) begin
        e.rw = 1'b0;
      end else begin
        e.rw  = rw & ~mis;
        e.rs  = (rs == 2'b11) ? 2'b00 : rs;
        e.alu = addr;
        e.pc4 = pc4;
        e.rd  = rd;
        if (acc && !mw) e.rdat = rdata;
      end
      exp_q.push_back(e);
      last_w = e;
      @(posedge clk);
      #1;
      check_w();
      @(negedge clk);
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rv;
    rst         = 1'b0;
    RegWriteM   = 1'b0;
    MemWriteM   = 1'b0;
    ResultSrcM  = 2'b00;
    ALU_ResultM = '0;
    WriteDataM  = '0;
    PCPlus4M    = '0;
    RD_M        = '0;
    dmem_ack    = 1'b0;
    dmem_rdata  = '0;
    last_w      = '0;
    @(negedge clk);

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      rv          = $urandom;
      RegWriteM   = rv[0];
      MemWriteM   = rv[1];
      ResultSrcM  = rv[3:2];
      dmem_ack    = rv[4];
      ALU_ResultM = $urandom;
      WriteDataM  = $urandom;
      PCPlus4M    = $urandom;
      RD_M        = rv[9:5];
      dmem_rdata  = $urandom;
      #1;
      check_port(1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_addr", dmem_addr, ALU_ResultM);
      exp_q.push_back('0);
      @(posedge clk);
      #1;
      check_w();
      @(negedge clk);
    end
    rst = 1'b1;

    // ALU pass-through, zero-wait load, two-wait store, back-to-back load.
    do_op(1'b1, 1'b0, 2'b00, 32'h10,  32'h0,    32'h4,  5'h0c, 0, 32'h5555_5555);
    do_op(1'b1, 1'b0, 2'b01, 32'h100, 32'h0,    32'h8,  5'h05, 0, 32'hDEAD_BEEF);
    do_op(1'b0, 1'b1, 2'b00, 32'h20,  32'h1234, 32'hC,  5'h00, 2, 32'hAAAA_AAAA);
    do_op(1'b1, 1'b0, 2'b01, 32'h104, 32'h0,    32'h10, 5'h07, 1, 32'hCAFE_F00D);
    do_op(1'b1, 1'b0, 2'b10, 32'h44,  32'h0,    32'h40, 5'h01, 0, 32'h0);
    // Misaligned load and store, store+load encoding, reserved ResultSrc.
    do_op(1'b1, 1'b0, 2'b01, 32'h102, 32'h0,    32'h14, 5'h03, 0, 32'h1111_1111);
    do_op(1'b0, 1'b1, 2'b00, 32'h21,  32'h99,   32'h18, 5'h00, 0, 32'h0);
    do_op(1'b0, 1'b1, 2'b01, 32'h30,  32'h77,   32'h1C, 5'h02, 1, 32'h2222_2222);
    do_op(1'b1, 1'b0, 2'b11, 32'h50,  32'h0,    32'h20, 5'h04, 0, 32'h0);

    for (int i = 0; i < 12; i++) begin
      rv = $urandom;
      ra = $urandom;
      if (rv[7:6] != 2'b00) ra[1:0] = 2'b00;
      do_op(rv[0], rv[1], rv[3:2], ra, $urandom, $urandom, rv[12:8],
            int'(rv[5:4]), $urandom);
    end

    // Reset while a load waits; the late ack must be ignored.
    RegWriteM   = 1'b1;
    MemWriteM   = 1'b0;
    ResultSrcM  = 2'b01;
    ALU_ResultM = 32'h200;
    RD_M        = 5'h09;
    dmem_ack    = 1'b0;
    #1;
    check_port(1'b1, 1'b0, 1'b1, 1'b0);
    last_w.rw = 1'b0;
    exp_q.push_back(last_w);
    @(posedge clk);
    #1;
    check_w();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_port(1'b0, 1'b0, 1'b0, 1'b0);
    last_w = '0;
    exp_q.push_back(last_w);
    @(posedge clk);
    #1;
    check_w();
    @(negedge clk);
    rst = 1'b1;
    do_op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'h00, 0, 32'h3333_3333);
    do_op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'h00, 0, 32'h4444_4444);
    do_op(1'b1, 1'b0, 2'b00, 32'h60, 32'h0, 32'h24, 5'h0a, 0, 32'h0);
    do_op(1'b1, 1'b0, 2'b01, 32'h208, 32'h0, 32'h28, 5'h0b, 1, 32'h600D_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
